// File: rtl/imem_loader.sv
// Boot loader: unpacks a length-prefixed byte stream into big-endian 32-bit
// instruction-memory writes and holds the core in reset until the load ends.
module imem_loader #(
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   // One extra bit so a 16-bit header count compares cleanly against the depth.
   localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

   state_t      state_r,     state_s;
   logic [15:0] count_r,     count_s;
   logic [31:0] word_r,      word_s;
   logic [1:0]  byte_idx_r,  byte_idx_s;
   logic [15:0] word_idx_r,  word_idx_s;
   logic        mem_we_r,    mem_we_s;
   logic [31:0] mem_addr_r,  mem_addr_s;
   logic [31:0] mem_wdata_r, mem_wdata_s;
   logic        cpu_hold_r,  cpu_hold_s;
   logic        done_r,      done_s;
   logic        err_r,       err_s;

   logic        ready_state_s;
   logic        accept_s;
   logic [15:0] header_s;
   logic [31:0] word_next_s;
   logic [15:0] word_idx_inc_s;

   // Ready decode: only header/data states take bytes, never while in reset.
   always_comb begin
      ready_state_s = 1'b0;
      case (state_r)
         ST_HDR_HI: ready_state_s = 1'b1;
         ST_HDR_LO: ready_state_s = 1'b1;
         ST_DATA:   ready_state_s = 1'b1;
         default:   ready_state_s = 1'b0;
      endcase
   end

   assign in_ready       = ready_state_s & ~rstn;
   assign accept_s       = in_valid & in_ready;
   assign header_s       = {count_r[15:8], in_data};
   assign word_next_s    = {word_r[23:0], in_data};
   assign word_idx_inc_s = word_idx_r + 16'd1;

   // Next-state and next-output logic for the load sequence.
   always_comb begin
      state_s     = state_r;
      count_s     = count_r;
      word_s      = word_r;
      byte_idx_s  = byte_idx_r;
      word_idx_s  = word_idx_r;
      mem_we_s    = 1'b0;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      cpu_hold_s  = cpu_hold_r;
      done_s      = done_r;
      err_s       = err_r;

      case (state_r)
         ST_HDR_HI: begin
            if (accept_s) begin
               count_s[15:8] = in_data;
               state_s       = ST_HDR_LO;
            end else begin
               state_s = ST_HDR_HI;
            end
         end

         ST_HDR_LO: begin
            if (accept_s) begin
               count_s = header_s;
               if (header_s == 16'd0) begin
                  state_s    = ST_DONE;
                  done_s     = 1'b1;
                  cpu_hold_s = 1'b0;
               end else if ({1'b0, header_s} > MAX_WORDS_C) begin
                  state_s = ST_ERR;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_HDR_LO;
            end
         end

         ST_DATA: begin
            if (accept_s) begin
               word_s = word_next_s;
               if (byte_idx_r == 2'd3) begin
                  // Launch the write registers now so the pulse lines up with WRITE.
                  byte_idx_s  = 2'd0;
                  state_s     = ST_WRITE;
                  mem_we_s    = 1'b1;
                  mem_addr_s  = BASE_ADDR + {14'd0, word_idx_r, 2'b00};
                  mem_wdata_s = word_next_s;
               end else begin
                  byte_idx_s = byte_idx_r + 2'd1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end

         ST_WRITE: begin
            word_idx_s = word_idx_inc_s;
            if (word_idx_inc_s == count_r) begin
               state_s    = ST_DONE;
               done_s     = 1'b1;
               cpu_hold_s = 1'b0;
            end else begin
               state_s = ST_DATA;
            end
         end

         ST_DONE: begin
            state_s = ST_DONE;
         end

         ST_ERR: begin
            state_s = ST_ERR;
         end

         default: begin
            state_s = ST_HDR_HI;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_r     <= ST_HDR_HI;
         count_r     <= 16'd0;
         word_r      <= 32'd0;
         byte_idx_r  <= 2'd0;
         word_idx_r  <= 16'd0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= BASE_ADDR;
         mem_wdata_r <= 32'd0;
         cpu_hold_r  <= 1'b1;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         count_r     <= count_s;
         word_r      <= word_s;
         byte_idx_r  <= byte_idx_s;
         word_idx_r  <= word_idx_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         cpu_hold_r  <= cpu_hold_s;
         done_r      <= done_s;
         err_r       <= err_s;
      end
   end

   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_hold  = cpu_hold_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle table for the gapless load,
// hand sequences for empty/oversize headers, backpressure and mid-load reset.
module tb_imem_loader;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write pulse away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
   end

   typedef struct {
      logic        rstn;
      logic        vld;
      logic [7:0]  data;
      logic        rdy;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        hold;
      logic        dn;
      logic        er;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic rdy, logic we,
                               logic [31:0] a, logic [31:0] w, logic h, logic dn, logic er);
      vec_t x;
      x.rstn = r; x.vld = v; x.data = d; x.rdy = rdy; x.we = we;
      x.addr = a; x.wdata = w; x.hold = h; x.dn = dn; x.er = er;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Present one byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int cnt;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      if (cnt >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_byte_timeout: byte %h not accepted within 50 cycles", b);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   logic [7:0] stream[10];

   initial begin
      rstn = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;

      vt[0]  = mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[1]  = mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[2]  = mk(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[3]  = mk(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[4]  = mk(1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[5]  = mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[6]  = mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0);
      vt[7]  = mk(1'b0, 1'b1, 8'h8C, 1'b0, 1'b1, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      vt[8]  = mk(1'b0, 1'b1, 8'h8C, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      vt[9]  = mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      vt[10] = mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      vt[11] = mk(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0);
      vt[12] = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 32'h4, 32'h8C010004, 1'b1, 1'b0, 1'b0);
      vt[13] = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h4, 32'h8C010004, 1'b0, 1'b1, 1'b0);

      stream[0] = 8'h00; stream[1] = 8'h02; stream[2] = 8'h20; stream[3] = 8'h08;
      stream[4] = 8'h00; stream[5] = 8'h05; stream[6] = 8'h8C; stream[7] = 8'h01;
      stream[8] = 8'h00; stream[9] = 8'h04;

      // Gapless load, cycle by cycle; vt[0] also checks the reset state.
      @(posedge clk);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rstn     = vt[i].rstn;
         in_valid = vt[i].vld;
         in_data  = vt[i].data;
         #1;
         check($sformatf("v%0d_in_ready", i),  {31'd0, in_ready}, {31'd0, vt[i].rdy});
         check($sformatf("v%0d_mem_we", i),    {31'd0, mem_we},   {31'd0, vt[i].we});
         check($sformatf("v%0d_mem_addr", i),  mem_addr,          vt[i].addr);
         check($sformatf("v%0d_mem_wdata", i), mem_wdata,         vt[i].wdata);
         check($sformatf("v%0d_cpu_hold", i),  {31'd0, cpu_hold}, {31'd0, vt[i].hold});
         check($sformatf("v%0d_done", i),      {31'd0, done},     {31'd0, vt[i].dn});
         check($sformatf("v%0d_err", i),       {31'd0, err},      {31'd0, vt[i].er});
      end

      // Sticky done: further bytes are refused.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'(i);
         #1;
         check("done_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("done_hold_mem_we",   {31'd0, mem_we},   32'd0);
         check("done_hold_done",     {31'd0, done},     32'd1);
      end
      check("gapless_write_count", wr_addr_q.size(), 32'd2);

      // Empty program.
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("n0_done",     {31'd0, done},     32'd1);
      check("n0_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      idle(3);
      check("n0_write_count", wr_addr_q.size(), 32'd0);

      // Oversize header N=257.
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         #1;
         check("err_err",      {31'd0, err},      32'd1);
         check("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
         check("err_in_ready", {31'd0, in_ready}, 32'd0);
         check("err_done",     {31'd0, done},     32'd0);
      end
      idle(1);
      check("err_write_count", wr_addr_q.size(), 32'd0);

      // Random gaps; the byte after each word lands in WRITE and must wait.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send_byte(stream[i], (i == 6) ? 0 : int'($urandom_range(0, 3)));
      end
      idle(3);
      check("bp_write_count", wr_addr_q.size(), 32'd2);
      if (wr_addr_q.size() == 2) begin
         check("bp_addr0", wr_addr_q[0], 32'h0000_0000);
         check("bp_data0", wr_data_q[0], 32'h2008_0005);
         check("bp_addr1", wr_addr_q[1], 32'h0000_0004);
         check("bp_data1", wr_data_q[1], 32'h8C01_0004);
      end
      check("bp_done", {31'd0, done}, 32'd1);

      // Reset in the middle of the second word.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send_byte(stream[i], 0);
      end
      @(negedge clk);
      rstn     = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rstn     = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_mem_we",    {31'd0, mem_we},   32'd0);
      check("mid_rst_mem_addr",  mem_addr,          32'h0000_0000);
      check("mid_rst_mem_wdata", mem_wdata,         32'h0000_0000);
      check("mid_rst_cpu_hold",  {31'd0, cpu_hold}, 32'd1);
      check("mid_rst_done",      {31'd0, done},     32'd0);
      check("mid_rst_err",       {31'd0, err},      32'd0);
      wr_addr_q.delete();
      wr_data_q.delete();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      idle(3);
      check("mid_rst_write_count", wr_addr_q.size(), 32'd1);
      if (wr_addr_q.size() == 1) begin
         check("mid_rst_addr", wr_addr_q[0], 32'h0000_0000);
         check("mid_rst_data", wr_data_q[0], 32'hAABB_CCDD);
      end
      check("mid_rst_final_done",     {31'd0, done},     32'd1);
      check("mid_rst_final_cpu_hold", {31'd0, cpu_hold}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
